// File: rtl/waterfall_pkg.sv
// rtl/waterfall_pkg.sv - shared constants and types for the waterfall framebuffer writer
//
// Purpose: default geometry of the 320x240 8-bit framebuffer, frame size
//          and the writer state encoding.
// Ports:   none (package).
package waterfall_pkg;

  localparam int WIDTH_DEF  = 320;
  localparam int HEIGHT_DEF = 240;
  localparam int FRAME_SIZE = WIDTH_DEF * HEIGHT_DEF;

  // CLEAR only exists in builds with WATERFALL_CLEAR_EN; RUN is terminal.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wf_state_e;

endpackage

// File: rtl/waterfall_writer_if.sv
// rtl/waterfall_writer_if.sv - sample stream, display request and RAM port bundle
//
// Purpose: groups the writer's handshake and bus signals.
// Signals: s_data/s_valid/s_ready   sample stream into the writer
//          disp_req/disp_addr       display reader claim on the RAM port
//          ram_addr/ram_wdata/ram_we  single RAM port
//          scroll_row/line_done/busy  status back to the display side
// Modports: master = sample source / display side, slave = writer.
interface waterfall_writer_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [7:0]        scroll_row;
  logic              line_done;
  logic              busy;

  modport master (
    output s_data, s_valid, disp_req, disp_addr,
    input  s_ready, ram_addr, ram_wdata, ram_we, scroll_row, line_done, busy
  );

  modport slave (
    input  s_data, s_valid, disp_req, disp_addr,
    output s_ready, ram_addr, ram_wdata, ram_we, scroll_row, line_done, busy
  );

endinterface

// File: rtl/waterfall_addr_gen.sv
// rtl/waterfall_addr_gen.sv - column/row/base counters for the circular line buffer
//
// Purpose: tracks the current write column and row; base follows row*WIDTH
//          by accumulation so no multiplier is needed.
// Ports:   clk, reset_n   clock, asynchronous active-low reset
//          accept         a sample is written this cycle
//          wr_addr        base + col
//          scroll_row     oldest complete row (equals the row now being written)
//          line_done      one-cycle pulse after the last pixel of a line
module waterfall_addr_gen #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              accept,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        scroll_row,
  output logic              line_done
);

  localparam int COL_W = $clog2(WIDTH);

  logic [COL_W-1:0]  col_q;
  logic [7:0]        row_q;
  logic [ADDR_W-1:0] base_q;
  logic              last_col;
  logic              last_row;
  logic [7:0]        next_row;

  assign last_col = (col_q == COL_W'(WIDTH - 1));
  assign last_row = (row_q == 8'(HEIGHT - 1));
  assign next_row = last_row ? 8'd0 : row_q + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q     <= '0;
      row_q     <= '0;
      base_q    <= '0;
      line_done <= 1'b0;
    end else begin
      line_done <= accept & last_col;
      if (accept) begin
        if (last_col) begin
          col_q  <= '0;
          row_q  <= next_row;
          base_q <= last_row ? '0 : base_q + ADDR_W'(WIDTH);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  assign wr_addr = base_q + ADDR_W'(col_q);

  // The row being written is always the oldest one, so the display's raster
  // start and the write row share one register.
  assign scroll_row = row_q;

endmodule

// File: rtl/waterfall_writer.sv
// rtl/waterfall_writer.sv - waterfall line writer and RAM port arbiter
//
// Purpose: writes WIDTH-sample lines into a circular framebuffer, gives the
//          display reader priority on the single RAM port and publishes the
//          oldest row for scrolling.
// Ports:   clk       system clock
//          reset_n   asynchronous active-low reset
//          bus       waterfall_writer_if.slave (stream, display request,
//                    RAM port, scroll_row, line_done, busy)
// Build option: WATERFALL_CLEAR_EN adds a post-reset zero-fill of the whole
//          frame (CLEAR state); without it the writer starts in RUN and
//          busy is tied low.
module waterfall_writer
  import waterfall_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int HEIGHT = HEIGHT_DEF,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  waterfall_writer_if.slave   bus
);

  localparam int FRAME = WIDTH * HEIGHT;

  logic              is_run;
  logic              is_clear;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              accept;

`ifdef WATERFALL_CLEAR_EN
  wf_state_e         state_q;
  wf_state_e         state_d;
  logic [ADDR_W-1:0] clr_addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q <= state_d;
      // The fill pointer only advances on cycles the display leaves the port free.
      if (state_q == CLEAR && !bus.disp_req) begin
        clr_addr_q <= clr_addr_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == CLEAR && !bus.disp_req && clr_addr_q == ADDR_W'(FRAME - 1)) begin
      state_d = RUN;
    end
  end

  assign is_run   = (state_q == RUN);
  assign is_clear = (state_q == CLEAR);
  assign clr_addr = clr_addr_q;
`else
  assign is_run   = 1'b1;
  assign is_clear = 1'b0;
  assign clr_addr = '0;
`endif

  assign accept = is_run & bus.s_valid & ~bus.disp_req;

  waterfall_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .accept     (accept),
    .wr_addr    (wr_addr),
    .scroll_row (bus.scroll_row),
    .line_done  (bus.line_done)
  );

  // Display address goes straight to the RAM; its read latency comes only
  // from the RAM's own output register.
  assign bus.ram_addr  = bus.disp_req ? bus.disp_addr : (is_clear ? clr_addr : wr_addr);
  assign bus.ram_wdata = is_run ? bus.s_data : '0;
  assign bus.ram_we    = ~bus.disp_req & (is_clear | (is_run & bus.s_valid));
  assign bus.s_ready   = is_run & ~bus.disp_req;
  assign bus.busy      = is_clear;

endmodule

// File: tb/tb_waterfall_writer.sv
// tb/tb_waterfall_writer.sv - directed self-checking bench for waterfall_writer
module tb_waterfall_writer;

  localparam int WIDTH  = 320;
  localparam int HEIGHT = 240;
  localparam int FRAME  = WIDTH * HEIGHT;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int checks = 0;
  int errors = 0;

  waterfall_writer_if #(.ADDR_W(17), .DATA_W(8)) bus ();

  waterfall_writer #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (17),
    .DATA_W (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1: drive one sample, check the port mid-cycle, then
  // let the edge accept it.
  task automatic write_sample(input logic [7:0] d, input int exp_addr, input bit chk);
    bus.s_valid  = 1'b1;
    bus.s_data   = d;
    bus.disp_req = 1'b0;
    #4;
    if (chk) begin
      check("wr_we",    32'(bus.ram_we),    32'd1);
      check("wr_addr",  32'(bus.ram_addr),  32'(exp_addr));
      check("wr_data",  32'(bus.ram_wdata), 32'(d));
      check("wr_ready", 32'(bus.s_ready),   32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_line(input int row, input int first_col, input int last_col, input bit chk_all);
    for (int c = first_col; c <= last_col; c++) begin
      write_sample(8'(16 + c), row * WIDTH + c, chk_all || c == 0 || c == WIDTH - 1);
    end
  endtask

`ifdef WATERFALL_CLEAR_EN
  bit seen [FRAME];
`endif

  initial begin
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_scroll", 32'(bus.scroll_row), 32'd0);
    check("rst_done",   32'(bus.line_done),  32'd0);
    check("rst_we",     32'(bus.ram_we),     32'd0);
    check("rst_addr",   32'(bus.ram_addr),   32'd0);
`ifdef WATERFALL_CLEAR_EN
    check("rst_busy",   32'(bus.busy),       32'd1);
`else
    check("rst_busy",   32'(bus.busy),       32'd0);
`endif
    reset_n = 1'b1;

`ifdef WATERFALL_CLEAR_EN
    begin
      int cyc = 0;
      int writes = 0;
      int bad = 0;
      int rdy_seen = 0;
      while (bus.busy && cyc < 120000) begin
        bus.disp_req = (cyc % 4 == 3);
        bus.s_valid  = 1'b1;
        bus.s_data   = 8'hAA;
        #4;
        if (bus.s_ready) rdy_seen++;
        if (bus.ram_we) begin
          if (bus.ram_wdata != 8'h00) bad++;
          if (int'(bus.ram_addr) >= FRAME) bad++;
          else if (seen[bus.ram_addr]) bad++;
          else begin
            seen[bus.ram_addr] = 1'b1;
            writes++;
          end
        end
        @(posedge clk);
        #1;
        cyc++;
      end
      check("clr_timeout", 32'(bus.busy), 32'd0);
      check("clr_writes",  32'(writes),   32'(FRAME));
      check("clr_bad",     32'(bad),      32'd0);
      check("clr_ready",   32'(rdy_seen), 32'd0);
      bus.disp_req = 1'b0;
      bus.s_valid  = 1'b0;
      #4;
      check("clr_run_ready", 32'(bus.s_ready),  32'd1);
      check("clr_run_addr",  32'(bus.ram_addr), 32'd0);
      @(posedge clk);
      #1;
    end
`endif

    // Line 0 with every pixel checked
    write_line(0, 0, WIDTH - 1, 1'b1);
    check("l0_done",   32'(bus.line_done),  32'd1);
    check("l0_scroll", 32'(bus.scroll_row), 32'd1);

    // Idle: no write, counters stable, line_done was only one cycle
    bus.s_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      #4;
      check("idle_we",     32'(bus.ram_we),     32'd0);
      check("idle_addr",   32'(bus.ram_addr),   32'(WIDTH));
      check("idle_done",   32'(bus.line_done),  32'd0);
      check("idle_scroll", 32'(bus.scroll_row), 32'd1);
      @(posedge clk);
      #1;
    end

    // Line 1 with a display claim at col 100
    write_line(1, 0, 99, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.s_valid   = 1'b1;
      bus.s_data    = 8'(16 + 100);
      bus.disp_req  = 1'b1;
      bus.disp_addr = 17'h1234;
      #4;
      check("disp_addr",  32'(bus.ram_addr), 32'h1234);
      check("disp_we",    32'(bus.ram_we),   32'd0);
      check("disp_ready", 32'(bus.s_ready),  32'd0);
      @(posedge clk);
      #1;
    end
    write_line(1, 100, WIDTH - 1, 1'b1);
    check("l1_scroll", 32'(bus.scroll_row), 32'd2);
    check("l1_done",   32'(bus.line_done),  32'd1);

    // Remaining lines up to the wrap
    for (int r = 2; r < HEIGHT; r++) begin
      write_line(r, 0, WIDTH - 1, 1'b0);
    end
    check("wrap_scroll", 32'(bus.scroll_row), 32'd0);
    check("wrap_done",   32'(bus.line_done),  32'd1);

    // Line 241 starts at address 0
    write_sample(8'h10, 0, 1'b1);
    write_line(0, 1, WIDTH - 1, 1'b0);
    write_line(1, 0, WIDTH - 1, 1'b0);
    write_line(2, 0, WIDTH - 1, 1'b0);
    write_line(3, 0, 199, 1'b0);
    check("pre_rst_scroll", 32'(bus.scroll_row), 32'd3);

    // Asynchronous reset at row 3, col 200
    bus.s_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_scroll", 32'(bus.scroll_row), 32'd0);
    check("arst_addr",   32'(bus.ram_addr),   32'd0);
    check("arst_done",   32'(bus.line_done),  32'd0);
    check("arst_we",     32'(bus.ram_we),     32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
`ifdef WATERFALL_CLEAR_EN
    check("arst_busy", 32'(bus.busy), 32'd1);
`else
    write_sample(8'h55, 0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
